// File: rtl/param_rr_select.sv
// Round-robin select generator for the parameterized mux.
// Arbitrates among DEPTH requesters and holds each grant until the
// downstream consumer completes a valid/ready handshake. It then rotates
// priority so that the requester just served is searched last.
module param_rr_select #(
  parameter int DEPTH = 2,
  parameter int SEL_W = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [DEPTH-1:0] i_req,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [SEL_W-1:0] o_select,
  output logic [DEPTH-1:0] o_grant
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [DEPTH-1:0] grant_q, grant_d;

  logic [SEL_W-1:0] search_start;
  logic [SEL_W-1:0] sel_inc;
  logic [SEL_W-1:0] win;
  logic             hit;
  logic [DEPTH-1:0] req_sh;
  int               idx;

  // Circular search over i_req starting at search_start. On a handshake the
  // search starts just past the word being accepted, otherwise at ptr.
  always_comb begin
    sel_inc      = (sel_q == SEL_W'(DEPTH - 1)) ? '0 : sel_q + SEL_W'(1);
    search_start = (state_q == GRANT) ? sel_inc : ptr_q;
    hit          = 1'b0;
    win          = '0;
    idx          = 0;
    req_sh       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = int'(search_start) + k;
      if (idx >= DEPTH) idx = idx - DEPTH;
      req_sh = i_req >> idx;
      if (!hit && req_sh[0]) begin
        hit = 1'b1;
        win = SEL_W'(idx);
      end
    end
  end

  // Next-state logic: grab a winner from IDLE, hold through backpressure,
  // rotate on a handshake (back-to-back when another request is waiting).
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (hit) begin
          state_d = GRANT;
          sel_d   = win;
          grant_d = {{(DEPTH-1){1'b0}}, 1'b1} << win;
        end
      end
      GRANT: begin
        if (i_ready) begin
          ptr_d = sel_inc;
          if (hit) begin
            sel_d   = win;
            grant_d = {{(DEPTH-1){1'b0}}, 1'b1} << win;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State, pointer and registered outputs; reset wins over any handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
    end
  end

  assign o_valid  = (state_q == GRANT);
  assign o_select = sel_q;
  assign o_grant  = grant_q;

endmodule

// File: tb/tb_param_rr_select.sv
// Testbench for param_rr_select: a DEPTH=4 and a DEPTH=3 instance, directed
// scenarios followed by random traffic, checked against a queue-free
// behavioural model of the round-robin rules.
module tb_param_rr_select;

  logic       clk = 1'b0;
  logic       rst4, rdy4, rst3, rdy3;
  logic [3:0] req4;
  logic [2:0] req3;
  logic       vld4, vld3;
  logic [1:0] sel4, sel3;
  logic [3:0] gnt4;
  logic [2:0] gnt3;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // model state per instance: 0 -> DEPTH 4, 1 -> DEPTH 3
  int  m_depth [2] = '{4, 3};
  bit  m_valid [2];
  int  m_sel   [2];
  int  m_ptr   [2];
  bit  m_selk  [2];

  always #5 clk = ~clk;

  param_rr_select #(.DEPTH(4)) dut4 (
    .i_clk(clk), .i_rst(rst4), .i_req(req4), .i_ready(rdy4),
    .o_valid(vld4), .o_select(sel4), .o_grant(gnt4)
  );

  param_rr_select #(.DEPTH(3)) dut3 (
    .i_clk(clk), .i_rst(rst3), .i_req(req3), .i_ready(rdy3),
    .o_valid(vld3), .o_select(sel3), .o_grant(gnt3)
  );

  // First requesting index at or after start, circularly; -1 when none.
  function automatic int rr_find(input int req, input int start, input int d);
    for (int k = 0; k < d; k++) begin
      int i;
      i = (start + k) % d;
      if (((req >> i) & 1) == 1) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock for instance `inst`: drive, advance model, clock, compare.
  task automatic step(input int inst, input int req, input bit rdy, input bit rst, input string tag);
    int w;
    int d;
    d = m_depth[inst];
    @(negedge clk);
    if (inst == 0) begin
      req4 = req[3:0]; rdy4 = rdy; rst4 = rst;
    end else begin
      req3 = req[2:0]; rdy3 = rdy; rst3 = rst;
    end
    if (rst) begin
      m_valid[inst] = 0; m_sel[inst] = 0; m_ptr[inst] = 0; m_selk[inst] = 1;
    end else if (!m_valid[inst]) begin
      w = rr_find(req, m_ptr[inst], d);
      if (w >= 0) begin
        m_valid[inst] = 1; m_sel[inst] = w; m_selk[inst] = 1;
      end
    end else if (rdy) begin
      m_ptr[inst] = (m_sel[inst] + 1) % d;
      w = rr_find(req, m_ptr[inst], d);
      if (w >= 0) m_sel[inst] = w;
      else begin
        m_valid[inst] = 0; m_selk[inst] = 0;
      end
    end
    @(posedge clk);
    #1;
    if (inst == 0) begin
      chk({tag, ".valid"}, 32'(vld4), 32'(m_valid[0]));
      chk({tag, ".grant"}, 32'(gnt4), m_valid[0] ? (32'd1 << m_sel[0]) : 32'd0);
      if (m_selk[0]) chk({tag, ".select"}, 32'(sel4), 32'(m_sel[0]));
    end else begin
      chk({tag, ".valid"}, 32'(vld3), 32'(m_valid[1]));
      chk({tag, ".grant"}, 32'(gnt3), m_valid[1] ? (32'd1 << m_sel[1]) : 32'd0);
      if (m_selk[1]) chk({tag, ".select"}, 32'(sel3), 32'(m_sel[1]));
    end
  endtask

  initial begin
    rst4 = 1; rdy4 = 0; req4 = '0;
    rst3 = 1; rdy3 = 0; req3 = '0;

    // reset with all requesting, then first grant and rotation
    step(0, 4'b1111, 0, 1, "rst");
    step(0, 4'b1111, 0, 1, "rst");
    step(0, 4'b1111, 1, 0, "first");
    for (int i = 0; i < 8; i++) step(0, 4'b1111, 1, 0, "rotate");

    // backpressure hold on select 2 while requests change
    step(0, 4'b0000, 0, 1, "rst");
    step(0, 4'b0100, 0, 0, "bp.grant");
    step(0, 4'b0100, 0, 0, "bp.hold");
    step(0, 4'b0100, 0, 0, "bp.hold");
    step(0, 4'b0001, 0, 0, "bp.hold");
    step(0, 4'b0001, 0, 0, "bp.hold");
    step(0, 4'b0001, 0, 0, "bp.hold");
    step(0, 4'b0001, 1, 0, "bp.release");
    step(0, 4'b0001, 1, 0, "bp.again");

    // single requester and drain
    for (int i = 0; i < 4; i++) step(0, 4'b0010, 1, 0, "single");
    step(0, 4'b0000, 1, 0, "drain");
    step(0, 4'b0000, 1, 0, "idle");
    step(0, 4'b0000, 1, 0, "idle.ready");

    // reset while a handshake is pending on select 3
    step(0, 4'b0100, 0, 0, "mid.g2");
    step(0, 4'b1000, 1, 0, "mid.g3");
    step(0, 4'b1001, 1, 1, "mid.rst");
    step(0, 4'b1001, 0, 0, "mid.after");

    // random traffic on DEPTH 4
    for (int i = 0; i < 300; i++)
      step(0, int'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 49) == 0), "rand4");

    // DEPTH 3: sparse wrap, then random
    rst4 = 1;
    step(1, 3'b101, 0, 1, "d3.rst");
    for (int i = 0; i < 8; i++) step(1, 3'b101, 1, 0, "d3.sparse");
    for (int i = 0; i < 6; i++) step(1, 3'b111, 1, 0, "d3.rotate");
    for (int i = 0; i < 300; i++)
      step(1, int'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 49) == 0), "rand3");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
